wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- NM-way round-robin Wishbone (pipelined) arbiter. It shares one downstream WB slave port between several WB masters, e.g. multiple AXI-lite→WB bridges, or a bridge plus a debug master.
- Ownership is granted per bus cycle (CYC-locked), so a master keeps the bus from the CYC rise to the CYC fall.
- Includes an optional stuck-slave watchdog. It aborts a cycle with ERR so upstream AXI bridges never hang.

Parameters:
- NM, 4, number of masters (2..16)
- AW, 26, WB word-address width
- DW, 32, WB data width; select width is DW/8
- OPT_TIMEOUT, 0, watchdog limit in cycles; 0 disables the watchdog
- LGTO, 8, watchdog counter width; OPT_TIMEOUT < 2^LGTO

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_mcyc  in  NM  per-master CYC
- i_mstb  in  NM  per-master STB
- i_mwe  in  NM  per-master WE
- i_maddr  in  NM*AW  packed addresses; master k occupies [k*AW +: AW]
- i_mdata  in  NM*DW  packed write data
- i_msel  in  NM*DW/8  packed byte selects
- o_mack  out  NM  per-master ACK
- o_mstall  out  NM  per-master STALL
- o_merr  out  NM  per-master ERR
- o_mdata  out  DW  read data, broadcast to all masters
- o_scyc, o_sstb, o_swe  out  1  slave-side CYC, STB, WE
- o_saddr  out  AW  slave-side address
- o_sdata  out  DW  slave-side write data
- o_ssel  out  DW/8  slave-side byte selects
- i_sack, i_sstall, i_serr  in  1  slave ACK, STALL, ERR
- i_sdata  in  DW  slave read data
- o_grant  out  NM  one-hot current owner; all zero when the bus is unowned

Behaviour:
- Clock and reset:
  - Single clock i_clk; i_reset is synchronous and active-high.
  - Reset values: state=IDLE, r_grant=0, r_last=NM-1, watchdog=0.
  - Consequently o_scyc=0, o_sstb=0, o_mack=0, o_merr=0, o_mstall=all ones.
- State machine, registered:
  - IDLE: if any i_mcyc, select the first requester at index (r_last+1) mod NM, searching upward with wrap. Load the one-hot r_grant and go to OWNED on the next edge. Arbitration latency is exactly 1 cycle from CYC rise to grant.
  - OWNED: if i_mcyc[owner]=0, go to IDLE, set r_last<=owner, clear r_grant. If the watchdog expires, go to ABORT.
  - ABORT: o_scyc=0. Stay until i_mcyc[owner]=0, then go to IDLE and set r_last<=owner.
  - There is always at least one IDLE cycle between owners. No master-to-master handover occurs inside a cycle.
- Slave-side muxing (combinational from r_grant):
  - o_scyc = OWNED && i_mcyc[owner]
  - o_sstb = o_scyc && i_mstb[owner]
  - o_swe, o_saddr, o_sdata, o_ssel come from the owner's inputs.
  - All slave-side outputs are zero when unowned.
- Master-side returns:
  - o_mack[k] = OWNED && grant[k] && i_sack; o_merr[k] uses i_serr the same way.
  - ACK or ERR arriving in IDLE or ABORT is dropped.
  - o_mstall[k] = !(OWNED && grant[k]) || i_sstall.
  - o_mdata = i_sdata, unmuxed.
- Watchdog (OPT_TIMEOUT>0):
  - The counter clears on any i_sack or i_serr, and whenever not in OWNED.
  - It increments each OWNED cycle with o_scyc=1.
  - When the count equals OPT_TIMEOUT-1 and no ack/err arrives that cycle, drive o_merr[owner]=1 for one cycle and enter ABORT on the next edge.
  - With OPT_TIMEOUT=0 the ABORT state is unreachable.
- Boundary conditions:
  - Owner drops CYC while another master raises CYC in the same cycle: the new master is granted after one IDLE cycle.
  - A single requester is re-granted repeatedly, starting from any r_last.
  - Reset mid-cycle: o_scyc falls in the cycle after the reset edge, and outstanding acks are discarded.
  - The owner's STB may be asserted while the arbiter is in IDLE; the request is simply stalled.

Decomposition:
- Shared package wb_arb_pkg: state encoding (IDLE/OWNED/ABORT) and a one-hot→binary function.
- Sub-module rr_pick: combinational round-robin priority picker (inputs request vector and r_last; output one-hot grant).

Test Plan:
- NM=4, only master 2 raises CYC+STB at cycle 0 → o_grant=4'b0100 at cycle 1; o_saddr=master 2's address; a slave ack returns only o_mack[2].
- All 4 CYC held high, each owner drops CYC after one acked transfer → grant order 0,1,2,3,0 with exactly 1 IDLE cycle between owners.
- Master 1 owns with 3 pipelined STBs and i_sstall=1 for 2 cycles → o_mstall[1]=1 during the stall; 3 acks are routed to master 1; other masters' o_mstall stay 1 throughout.
- OPT_TIMEOUT=16, slave never acks → o_merr[owner] pulses exactly once, 16 cycles after o_scyc rose; o_scyc=0 from the next cycle until the owner drops CYC.
- i_reset asserted while master 3 owns with 2 acks outstanding → next cycle o_scyc=0, o_grant=0; later acks are not forwarded; after reset, master 0 is granted first if all masters request.
- Owner 0 drops CYC in the same cycle master 0 re-raises it and master 2 requests → master 2 is granted next, not master 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter.
// Holds the arbiter state encoding and the owner-index width.
// Provides a one-hot to binary helper for the current-owner vector.
package wb_arb_pkg;

    // Widest supported master count and the binary index width that covers it.
    localparam int MAX_NM = 16;
    localparam int OH_BW  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    // Encodes a one-hot vector into its bit index (OR-reduction, no priority chain).
    function automatic logic [OH_BW-1:0] onehot_to_bin(input logic [MAX_NM-1:0] oh);
        logic [OH_BW-1:0] b;
        b = '0;
        for (int i = 0; i < MAX_NM; i++) begin
            if (oh[i]) begin
                b = b | OH_BW'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Round-robin priority picker: first requester after i_last, searching upward with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is loaded.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NM = 4
) (
    input  logic [NM-1:0]    i_req,
    input  logic [OH_BW-1:0] i_last,
    output logic [NM-1:0]    o_grant
);

    localparam int LW = $clog2(NM);

    logic [LW-1:0] idx;
    logic          found;

    // Walk the NM slots starting just after the previous owner; the first hit wins.
    always_comb begin
        o_grant = '0;
        found   = 1'b0;
        idx     = '0;
        for (int off = 1; off <= NM; off++) begin
            idx = LW'((int'(i_last) + off) % NM);
            if (!found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// NM-way round-robin arbiter sharing one pipelined Wishbone slave, locked per CYC.
// Latency: grant one cycle after CYC rise; slave-side and return paths are combinational.
// Backpressure: non-owners see STALL high; the owner sees the slave's STALL directly.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NM          = 4,
    parameter int AW          = 26,
    parameter int DW          = 32,
    parameter int OPT_TIMEOUT = 0,
    parameter int LGTO        = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NM-1:0]           i_mcyc,
    input  logic [NM-1:0]           i_mstb,
    input  logic [NM-1:0]           i_mwe,
    input  logic [NM*AW-1:0]        i_maddr,
    input  logic [NM*DW-1:0]        i_mdata,
    input  logic [NM*(DW/8)-1:0]    i_msel,
    output logic [NM-1:0]           o_mack,
    output logic [NM-1:0]           o_mstall,
    output logic [NM-1:0]           o_merr,
    output logic [DW-1:0]           o_mdata,
    output logic                    o_scyc,
    output logic                    o_sstb,
    output logic                    o_swe,
    output logic [AW-1:0]           o_saddr,
    output logic [DW-1:0]           o_sdata,
    output logic [DW/8-1:0]         o_ssel,
    input  logic                    i_sack,
    input  logic                    i_sstall,
    input  logic                    i_serr,
    input  logic [DW-1:0]           i_sdata,
    output logic [NM-1:0]           o_grant
);

    localparam int               SW       = DW / 8;
    localparam bit               TO_EN    = (OPT_TIMEOUT > 0);
    localparam logic [LGTO-1:0]  TO_LAST  = LGTO'(TO_EN ? OPT_TIMEOUT - 1 : 0);
    localparam logic [OH_BW-1:0] LAST_RST = OH_BW'(NM - 1);

    arb_state_t         state_q, state_d;
    logic [NM-1:0]      grant_q, grant_d;
    logic [OH_BW-1:0]   last_q, last_d;
    logic [LGTO-1:0]    wdog_q, wdog_d;

    logic [NM-1:0]      pick;
    logic [MAX_NM-1:0]  grant_ext;
    logic [OH_BW-1:0]   owner;
    logic               owned;
    logic               owner_cyc;
    logic               owner_stb;
    logic               timeout_hit;

    rr_pick #(.NM(NM)) u_pick (
        .i_req   (i_mcyc),
        .i_last  (last_q),
        .o_grant (pick)
    );

    assign grant_ext = MAX_NM'(grant_q);
    assign owner     = onehot_to_bin(grant_ext);
    assign owned     = (state_q == ST_OWNED);

    // Route the owner's request fields to the slave; everything reads zero when nobody holds a grant.
    always_comb begin
        o_swe     = 1'b0;
        o_saddr   = '0;
        o_sdata   = '0;
        o_ssel    = '0;
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (grant_q[k]) begin
                o_swe     = i_mwe[k];
                o_saddr   = i_maddr[k*AW +: AW];
                o_sdata   = i_mdata[k*DW +: DW];
                o_ssel    = i_msel[k*SW +: SW];
                owner_cyc = i_mcyc[k];
                owner_stb = i_mstb[k];
            end
        end
    end

    assign o_scyc = owned && owner_cyc;
    assign o_sstb = o_scyc && owner_stb;

    // The watchdog fires on the last allowed silent cycle unless the slave answers in that same cycle.
    assign timeout_hit = TO_EN && o_scyc && (wdog_q == TO_LAST) && !i_sack && !i_serr;

    // Responses only reach the owner while OWNED; anything arriving in IDLE or ABORT is dropped.
    assign o_mack   = owned ? (grant_q & {NM{i_sack}}) : '0;
    assign o_merr   = owned ? (grant_q & {NM{i_serr || timeout_hit}}) : '0;
    assign o_mstall = ~(owned ? grant_q : '0) | {NM{i_sstall}};
    assign o_mdata  = i_sdata;
    assign o_grant  = grant_q;

    // Watchdog counts silent owned bus cycles and restarts on any slave response.
    always_comb begin
        wdog_d = wdog_q;
        if (!TO_EN || !owned || i_sack || i_serr) begin
            wdog_d = '0;
        end else if (o_scyc) begin
            wdog_d = wdog_q + LGTO'(1);
        end
    end

    // Ownership FSM: grant in IDLE, hold until the owner drops CYC, park in ABORT after a timeout.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|i_mcyc) begin
                    grant_d = pick;
                    state_d = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (!owner_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner;
                end else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (!owner_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset; last owner resets to NM-1 so master 0 wins first.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboarded bench for wb_rr_arbiter with a transaction-level ownership model.
// Stimulus pushes expected per-cycle outputs; a negedge monitor pops and compares.
// Directed episodes cover the grant order, timeout pulse, reset and handover cases.
module tb_wb_rr_arbiter;

    localparam int NM = 4;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic                clk;
    logic                i_reset;
    logic [NM-1:0]       i_mcyc, i_mstb, i_mwe;
    logic [NM*AW-1:0]    i_maddr;
    logic [NM*DW-1:0]    i_mdata;
    logic [NM*SW-1:0]    i_msel;
    logic [NM-1:0]       o_mack, o_mstall, o_merr, o_grant;
    logic [DW-1:0]       o_mdata, o_sdata, i_sdata;
    logic                o_scyc, o_sstb, o_swe;
    logic [AW-1:0]       o_saddr;
    logic [SW-1:0]       o_ssel;
    logic                i_sack, i_sstall, i_serr;

    wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .OPT_TIMEOUT(TO), .LGTO(8)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
        .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
        .o_mack(o_mack), .o_mstall(o_mstall), .o_merr(o_merr), .o_mdata(o_mdata),
        .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
        .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
        .i_sack(i_sack), .i_sstall(i_sstall), .i_serr(i_serr), .i_sdata(i_sdata),
        .o_grant(o_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NM-1:0] grant, mack, merr, mstall;
        logic          scyc, sstb, swe;
        logic [AW-1:0] saddr;
        logic [DW-1:0] sdata;
        logic [SW-1:0] ssel;
        logic [DW-1:0] mdata;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: who owns the bus, whether that ownership was aborted, who owned last,
    // and how many silent bus cycles the owner has seen.
    int m_owner, m_last, m_wd;
    bit m_abort;

    // Master / slave agent state.
    int      to_iss[NM];
    int      outst[NM];
    bit      errd[NM];
    int      slave_pend;
    logic [NM-1:0] req_mask;
    int      p_req, p_ack, p_stall, p_err, p_spur, p_rst, n_xfer;
    bit      noack;

    // Observation helpers filled by the monitor.
    bit            rec_on = 1'b0;
    int            rec[$];
    logic [NM-1:0] prev_g = '0;
    int            scyc_run = 0;
    bit            c_on = 1'b0;
    int            n_merr = 0;
    int            err_run = -1;
    logic [NM-1:0] err_vec = '0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    // Compute this cycle's expected outputs from the model, queue them, then advance the model.
    task automatic step();
        exp_t e;
        bit   active, expire;
        e      = '0;
        expire = 1'b0;
        active = (m_owner >= 0) && !m_abort;
        if (m_owner >= 0) begin
            e.grant[m_owner] = 1'b1;
            e.swe   = i_mwe[m_owner];
            e.saddr = i_maddr[m_owner*AW +: AW];
            e.sdata = i_mdata[m_owner*DW +: DW];
            e.ssel  = i_msel[m_owner*SW +: SW];
            e.scyc  = active && i_mcyc[m_owner];
            e.sstb  = e.scyc && i_mstb[m_owner];
            expire  = e.scyc && (m_wd == TO - 1) && !i_sack && !i_serr;
            if (active) begin
                e.mack[m_owner] = i_sack;
                e.merr[m_owner] = i_serr || expire;
            end
        end
        e.mstall = (active ? ~e.grant : {NM{1'b1}}) | {NM{i_sstall}};
        e.mdata  = i_sdata;
        sb.push_back(e);
        last_e = e;

        if (i_reset) begin
            m_owner = -1; m_abort = 1'b0; m_last = NM - 1; m_wd = 0;
        end else if (m_owner < 0) begin
            m_wd = 0;
            for (int n = 1; n <= NM; n++) begin
                if (m_owner < 0 && i_mcyc[(m_last + n) % NM]) m_owner = (m_last + n) % NM;
            end
        end else if (!i_mcyc[m_owner]) begin
            m_last = m_owner; m_owner = -1; m_abort = 1'b0; m_wd = 0;
        end else if (!m_abort) begin
            if (expire) begin
                m_abort = 1'b1; m_wd = 0;
            end else if (i_sack || i_serr) begin
                m_wd = 0;
            end else if (e.scyc) begin
                m_wd++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Masters and slave react to what was expected in the cycle just finished.
    task automatic agent_post();
        if (i_reset) begin
            for (int k = 0; k < NM; k++) begin
                to_iss[k] = 0; outst[k] = 0; errd[k] = 1'b0;
            end
            i_mcyc = '0; i_mstb = '0; slave_pend = 0;
        end else begin
            if (last_e.sstb && !i_sstall) begin
                for (int k = 0; k < NM; k++) begin
                    if (last_e.grant[k]) begin to_iss[k]--; outst[k]++; end
                end
                slave_pend++;
            end
            for (int k = 0; k < NM; k++) begin
                if (last_e.mack[k] && outst[k] > 0) outst[k]--;
                if (last_e.merr[k]) errd[k] = 1'b1;
            end
        end
    endtask

    // Drive the next cycle's master and slave inputs.
    task automatic agent_pre();
        i_reset = ($urandom_range(0, 999) < p_rst);
        for (int k = 0; k < NM; k++) begin
            if (i_mcyc[k]) begin
                if (errd[k] || (to_iss[k] <= 0 && outst[k] == 0)) begin
                    i_mcyc[k] = 1'b0; i_mstb[k] = 1'b0;
                end else begin
                    i_mstb[k] = (to_iss[k] > 0);
                end
            end else if (req_mask[k] && $urandom_range(0, 99) < p_req) begin
                i_mcyc[k] = 1'b1; i_mstb[k] = 1'b1;
                to_iss[k] = $urandom_range(1, n_xfer); outst[k] = 0; errd[k] = 1'b0;
            end else begin
                i_mstb[k] = 1'b0;
            end
            i_maddr[k*AW +: AW] = AW'($urandom);
            i_mdata[k*DW +: DW] = $urandom;
            i_msel[k*SW +: SW]  = SW'($urandom);
            i_mwe[k]            = 1'($urandom);
        end
        if (!(m_owner >= 0 && !m_abort)) slave_pend = 0;
        i_sstall = ($urandom_range(0, 99) < p_stall);
        i_sack = 1'b0; i_serr = 1'b0;
        if (slave_pend > 0) begin
            if (!noack && $urandom_range(0, 99) < p_ack) begin
                if ($urandom_range(0, 99) < p_err) i_serr = 1'b1;
                else i_sack = 1'b1;
                slave_pend--;
            end
        end else if ($urandom_range(0, 99) < p_spur) begin
            i_sack = 1'b1;
        end
        i_sdata = $urandom;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            agent_pre();
            step();
            agent_post();
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_mcyc = '0; i_mstb = '0;
        i_sack = 1'b0; i_serr = 1'b0; i_sstall = 1'b0;
        step();
        agent_post();
        i_reset = 1'b0;
    endtask

    task automatic set_mode(input logic [NM-1:0] mask, input int req, input int xfer,
                            input int ack, input int stall, input int err, input int spur,
                            input bit na, input int rst);
        req_mask = mask; p_req = req; n_xfer = xfer; p_ack = ack; p_stall = stall;
        p_err = err; p_spur = spur; noack = na; p_rst = rst;
    endtask

    task automatic rec_start();
        rec.delete();
        rec_on = 1'b1;
    endtask

    function automatic void rec_check(input string nm, input int idx, input int exp);
        chk($sformatf("%s[%0d]", nm, idx), 64'(rec.size() > idx ? rec[idx] : 99), 64'(exp));
    endfunction

    // Monitor: compare every queued expectation against the DUT and note grant/timeout events.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("grant",  64'(o_grant),  64'(mon_e.grant));
            chk("scyc",   64'(o_scyc),   64'(mon_e.scyc));
            chk("sstb",   64'(o_sstb),   64'(mon_e.sstb));
            chk("swe",    64'(o_swe),    64'(mon_e.swe));
            chk("saddr",  64'(o_saddr),  64'(mon_e.saddr));
            chk("sdata",  64'(o_sdata),  64'(mon_e.sdata));
            chk("ssel",   64'(o_ssel),   64'(mon_e.ssel));
            chk("mack",   64'(o_mack),   64'(mon_e.mack));
            chk("merr",   64'(o_merr),   64'(mon_e.merr));
            chk("mstall", 64'(o_mstall), 64'(mon_e.mstall));
            chk("mdata",  64'(o_mdata),  64'(mon_e.mdata));
        end
        if (rec_on && o_grant != '0 && o_grant != prev_g) begin
            for (int k = 0; k < NM; k++) if (o_grant[k]) rec.push_back(k);
        end
        prev_g = o_grant;
        if (o_scyc) scyc_run++;
        else scyc_run = 0;
        if (c_on && o_merr != '0) begin
            n_merr++;
            if (n_merr == 1) begin err_run = scyc_run; err_vec = o_merr; end
        end
    end

    initial begin
        int ord_b[5];
        ord_b = '{0, 1, 2, 3, 0};
        i_reset = 1'b1; i_mcyc = '0; i_mstb = '0; i_mwe = '0;
        i_maddr = '0; i_mdata = '0; i_msel = '0;
        i_sack = 1'b0; i_sstall = 1'b0; i_serr = 1'b0; i_sdata = '0;
        m_owner = -1; m_abort = 1'b0; m_last = NM - 1; m_wd = 0; slave_pend = 0;
        for (int k = 0; k < NM; k++) begin to_iss[k] = 0; outst[k] = 0; errd[k] = 1'b0; end
        set_mode('0, 0, 1, 0, 0, 0, 0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Lone master 2.
        rec_start();
        set_mode(4'b0100, 100, 2, 100, 0, 0, 0, 1'b0, 0);
        run(12);
        rec_check("lone", 0, 2);

        // All four request back to back, one transfer each.
        set_mode('0, 0, 1, 100, 0, 0, 0, 1'b0, 0);
        do_reset();
        rec_start();
        set_mode(4'b1111, 100, 1, 100, 0, 0, 0, 1'b0, 0);
        run(30);
        for (int i = 0; i < 5; i++) rec_check("order", i, ord_b[i]);

        // Stuck slave: master 1 times out once.
        set_mode('0, 0, 1, 0, 0, 0, 0, 1'b0, 0);
        do_reset();
        c_on = 1'b1; n_merr = 0;
        set_mode(4'b0010, 100, 3, 0, 0, 0, 0, 1'b1, 0);
        run(30);
        c_on = 1'b0;
        chk("to_pulses", 64'(n_merr), 64'd1);
        chk("to_delay", 64'(err_run), 64'(TO));
        chk("to_owner", 64'(err_vec), 64'(4'b0010));

        // Reset with two accepted STBs outstanding at master 3; late acks must vanish.
        set_mode('0, 0, 1, 0, 0, 0, 0, 1'b0, 0);
        do_reset();
        rec_start();
        i_mcyc = 4'b1000; i_mstb = 4'b1000;
        step(); step(); step();
        i_mstb = '0;
        step();
        i_reset = 1'b1; step(); i_reset = 1'b0;
        i_mcyc = '0; i_sack = 1'b1;
        step(); step();
        i_sack = 1'b0;
        i_mcyc = 4'b1111; i_mstb = 4'b1111;
        step(); step(); step();
        i_mcyc = '0; i_mstb = '0;
        step(); step();
        rec_check("rst", 0, 3);
        rec_check("rst", 1, 0);

        // Owner 0 drops as master 2 requests, then 0 re-raises during the IDLE gap.
        do_reset();
        rec_start();
        i_mcyc = 4'b0001; i_mstb = 4'b0001;
        step(); step();
        i_mcyc = 4'b0100; i_mstb = 4'b0100;
        step();
        i_mcyc = 4'b0101; i_mstb = 4'b0101;
        step(); step();
        i_mcyc = '0; i_mstb = '0;
        step(); step();
        rec_check("handover", 0, 0);
        rec_check("handover", 1, 2);
        rec_on = 1'b0;

        // Random traffic with stalls, errors, spurious acks and occasional resets.
        do_reset();
        set_mode(4'b1111, 30, 4, 60, 25, 5, 5, 1'b0, 2);
        run(3000);
        set_mode(4'b1111, 40, 3, 5, 30, 10, 5, 1'b0, 2);
        run(1000);

        @(negedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
